popcount_pipe_acc: RTL and testbench
====================================

Name: popcount_pipe_acc

Overview:
Parametrised, pipelined population-count engine for wide vectors. Each input is split into 6-bit groups, one LUT6 popcount per group, followed by a registered adder tree. An optional XOR stage gives Hamming-distance mode. An optional frame accumulator sums counts across multi-beat frames. It sits between the feature/signature streaming datapath and the match/compare logic, using valid/ready streams on both sides.

Parameters:
DIN_WIDTH, 64, input vector width; any value ≥1.
ACC_WIDTH, 16, frame accumulator and output width; must be ≥ CNT_WIDTH.
CNT_WIDTH, $clog2(DIN_WIDTH+1), width of a single-beat count (derived, do not override).
NGROUPS, ceil(DIN_WIDTH/6), number of LUT6 groups (derived).
TREE_LVLS, ceil(log2(NGROUPS)), adder tree levels, 0 when NGROUPS=1 (derived).

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  DIN_WIDTH  vector to count
s_ref  in  DIN_WIDTH  reference vector, used only when s_xor=1
s_xor  in  1  per-beat: count ones of s_data^s_ref instead of s_data
s_acc  in  1  per-beat: add into frame accumulator instead of emitting directly
s_last  in  1  per-beat: final beat of frame; ignored when s_acc=0
m_valid  out  1  result valid
m_ready  in  1  downstream accept
m_count  out  ACC_WIDTH  result: beat count (zero-extended) or frame total
m_frame  out  1  1 = m_count is a frame total, 0 = single-beat count
m_sat  out  1  frame total saturated (only meaningful when m_frame=1)

Behaviour:
- Pipeline: stage S0 registers the (optionally XORed) data and the sideband bits (xor, acc, last). S1 registers the per-group LUT6 counts; the last group is zero-padded when DIN_WIDTH%6≠0. S2..S(1+TREE_LVLS) are pairwise adder levels; an odd group passes through registered. The final stage SA is the accumulate/output register. Latency from accepted beat to m_valid = 3+TREE_LVLS cycles with no stall (default 64: 11 groups, 4 levels, 7 cycles).
- Each stage carries a valid bit. Global enable adv = !m_valid || m_ready. All stages hold when adv=0. s_ready = adv (combinational; no dependence on s_valid).
- Per-group LUT contents are computed at elaboration as constant tables (distributed ROM). Tree sum widths grow by 1 bit per level, and the final sum is truncated to CNT_WIDTH (lossless).
- SA stage, on adv with incoming valid beat v, count c:
  - acc=0: m_valid←1, m_count←zero-ext(c), m_frame←0, m_sat←0. The accumulator is untouched, so a non-acc beat may be interleaved inside a frame.
  - acc=1, last=0: acc_reg←sat(acc_reg+c), sat_flag|=overflow. m_valid←0.
  - acc=1, last=1: m_count←sat(acc_reg+c), m_sat←sat_flag|overflow, m_frame←1, m_valid←1. acc_reg←0, sat_flag←0.
  - No incoming valid beat: m_valid←0 when the output was consumed (m_ready), else hold.
- Saturation: sum clamps to 2^ACC_WIDTH-1, and the sticky sat flag is set.
- Empty frame (a lone beat with acc=1, last=1) outputs that beat's count.
- m_* outputs are stable while m_valid&&!m_ready. Upstream may drop s_valid at any time, and bubbles propagate.
- Reset: every stage valid, m_valid, m_count, m_frame, m_sat, acc_reg and sat_flag go to 0. s_ready=1 during the first cycle after reset. Reset mid-frame discards the partial frame and all in-flight beats; no output is produced for them.

Test Plan:
- DIN_WIDTH=64, s_data=64'hFFFF_FFFF_FFFF_FFFF, acc=0, m_ready=1 → m_count=64, m_frame=0 exactly 7 cycles after acceptance. s_data=0 → 0. s_data=64'h8000_0000_0000_0001 → 2.
- XOR mode: s_data=64'hF0F0…F0, s_ref=64'h0F0F…0F → 64. s_ref=s_data → 0. Same values with s_xor=0 → 32.
- Frame: 4 beats with counts 10,20,30,5, s_acc=1, last on 4th → single m_valid with m_count=65, m_frame=1, m_sat=0. A non-acc beat (count 7) inserted after beat 2 yields m_count=7, m_frame=0, and the frame total is still 65.
- Saturation: ACC_WIDTH=8, 5 all-ones 64-bit beats in one frame → m_count=255, m_sat=1. The next frame of 1 beat with count 3 → 3, m_sat=0.
- Backpressure: 20 back-to-back random beats with m_ready toggling pseudo-randomly → no loss or duplication, order preserved, m_* held stable while stalled, s_ready==adv each cycle. Compare against a reference popcount model.
- Reset after 2 of 4 frame beats plus 3 in flight → no outputs. A new 1-beat frame with count 9 → 9. Also sweep DIN_WIDTH=1,6,7,13 with exhaustive or random checks against the model.

Source files
------------

// File: rtl/popcount_pipe_acc_if.sv
// Stream interface for the popcount engine: input beats with sideband
// control on the s_* side, counts/frame totals on the m_* side.
interface popcount_pipe_acc_if #(
    parameter int DIN_WIDTH = 64,
    parameter int ACC_WIDTH = 16
);
    logic                 s_valid;
    logic                 s_ready;
    logic [DIN_WIDTH-1:0] s_data;
    logic [DIN_WIDTH-1:0] s_ref;
    logic                 s_xor;
    logic                 s_acc;
    logic                 s_last;
    logic                 m_valid;
    logic                 m_ready;
    logic [ACC_WIDTH-1:0] m_count;
    logic                 m_frame;
    logic                 m_sat;

    // producer of beats / consumer of results
    modport master (
        output s_valid, s_data, s_ref, s_xor, s_acc, s_last, m_ready,
        input  s_ready, m_valid, m_count, m_frame, m_sat
    );

    // the popcount engine itself
    modport slave (
        input  s_valid, s_data, s_ref, s_xor, s_acc, s_last, m_ready,
        output s_ready, m_valid, m_count, m_frame, m_sat
    );
endinterface

// File: rtl/popcount_pipe_acc.sv
// Pipelined population count: 6-bit LUT groups, registered adder tree,
// optional XOR (Hamming distance) and saturating multi-beat frame sums.
module popcount_pipe_acc #(
    parameter int DIN_WIDTH = 64,
    parameter int ACC_WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    popcount_pipe_acc_if.slave bus
);
    localparam int CNT_WIDTH = $clog2(DIN_WIDTH + 1);
    localparam int NGROUPS   = (DIN_WIDTH + 5) / 6;
    localparam int TREE_LVLS = $clog2(NGROUPS);
    // Every tree node is SUM_W wide; at level l only the low 3+l bits can be
    // non-zero, so the upper bits are constant and fold away in synthesis.
    localparam int SUM_W     = 3 + TREE_LVLS;
    localparam int SUMX_W    = ACC_WIDTH + 1;
    // Sideband/valid stages: S0, S1 (LUT counts), then one per tree level.
    localparam int NSTG      = TREE_LVLS + 2;

    function automatic logic [63:0][2:0] pop6_table();
        logic [63:0][2:0] t;
        for (int i = 0; i < 64; i++) begin
            t[i] = 3'd0;
            for (int b = 0; b < 6; b++) begin
                t[i] = t[i] + 3'((i >> b) & 1);
            end
        end
        return t;
    endfunction

    localparam logic [63:0][2:0] POP6 = pop6_table();

    logic                 adv;
    logic [DIN_WIDTH-1:0] data_s0_d, data_s0_q;
    logic [NSTG-1:0]      vld_d, vld_q;
    logic [NSTG-1:0]      acc_d, acc_q;
    logic [NSTG-1:0]      last_d, last_q;
    logic [NGROUPS*6-1:0] data_pad;
    logic [SUM_W-1:0]     tree_d [TREE_LVLS+1][NGROUPS];
    logic [SUM_W-1:0]     tree_q [TREE_LVLS+1][NGROUPS];
    logic [CNT_WIDTH-1:0] cnt;
    logic [SUMX_W-1:0]    sum_ext;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] acc_reg_d, acc_reg_q;
    logic                 sat_flag_d, sat_flag_q;
    logic                 m_valid_d, m_valid_q;
    logic [ACC_WIDTH-1:0] m_count_d, m_count_q;
    logic                 m_frame_d, m_frame_q;
    logic                 m_sat_d, m_sat_q;

    // The whole pipe moves together; a held result freezes every stage.
    assign adv         = !m_valid_q || bus.m_ready;
    assign bus.s_ready = adv;
    assign bus.m_valid = m_valid_q;
    assign bus.m_count = m_count_q;
    assign bus.m_frame = m_frame_q;
    assign bus.m_sat   = m_sat_q;

    // S0 intake: apply the XOR up front so later stages only count ones.
    always_comb begin
        data_s0_d = data_s0_q;
        vld_d     = vld_q;
        acc_d     = acc_q;
        last_d    = last_q;
        if (adv) begin
            data_s0_d = bus.s_xor ? (bus.s_data ^ bus.s_ref) : bus.s_data;
            vld_d     = {vld_q[NSTG-2:0], bus.s_valid};
            acc_d     = {acc_q[NSTG-2:0], bus.s_acc};
            last_d    = {last_q[NSTG-2:0], bus.s_last};
        end
    end

    // S1 LUT6 group counts and the pairwise adder levels behind them.
    always_comb begin
        data_pad                = '0;
        data_pad[DIN_WIDTH-1:0] = data_s0_q;
        tree_d                  = tree_q;
        if (adv) begin
            for (int k = 0; k < NGROUPS; k++) begin
                tree_d[0][k] = SUM_W'(POP6[data_pad[6*k +: 6]]);
            end
            for (int l = 1; l <= TREE_LVLS; l++) begin
                for (int k = 0; k < NGROUPS; k++) begin
                    tree_d[l][k] = '0;
                    if (2*k < NGROUPS) begin
                        tree_d[l][k] = tree_q[l-1][2*k];
                    end
                    if (2*k + 1 < NGROUPS) begin
                        tree_d[l][k] = tree_q[l-1][2*k] + tree_q[l-1][2*k+1];
                    end
                end
            end
        end
    end

    assign cnt = tree_q[TREE_LVLS][0][CNT_WIDTH-1:0];

    // SA stage: emit single-beat counts directly, or fold into the frame sum.
    always_comb begin
        sum_ext    = {1'b0, acc_reg_q} + SUMX_W'(cnt);
        ovf        = sum_ext[ACC_WIDTH];
        sum_sat    = ovf ? '1 : sum_ext[ACC_WIDTH-1:0];
        acc_reg_d  = acc_reg_q;
        sat_flag_d = sat_flag_q;
        m_valid_d  = m_valid_q;
        m_count_d  = m_count_q;
        m_frame_d  = m_frame_q;
        m_sat_d    = m_sat_q;
        if (adv) begin
            m_valid_d = 1'b0;
            if (vld_q[NSTG-1]) begin
                if (!acc_q[NSTG-1]) begin
                    m_valid_d = 1'b1;
                    m_count_d = ACC_WIDTH'(cnt);
                    m_frame_d = 1'b0;
                    m_sat_d   = 1'b0;
                end else if (!last_q[NSTG-1]) begin
                    acc_reg_d  = sum_sat;
                    sat_flag_d = sat_flag_q | ovf;
                end else begin
                    m_valid_d  = 1'b1;
                    m_count_d  = sum_sat;
                    m_sat_d    = sat_flag_q | ovf;
                    m_frame_d  = 1'b1;
                    acc_reg_d  = '0;
                    sat_flag_d = 1'b0;
                end
            end
        end
    end

    // All pipeline state; reset drops in-flight beats and any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_s0_q  <= '0;
            vld_q      <= '0;
            acc_q      <= '0;
            last_q     <= '0;
            for (int l = 0; l <= TREE_LVLS; l++) begin
                for (int k = 0; k < NGROUPS; k++) begin
                    tree_q[l][k] <= '0;
                end
            end
            acc_reg_q  <= '0;
            sat_flag_q <= 1'b0;
            m_valid_q  <= 1'b0;
            m_count_q  <= '0;
            m_frame_q  <= 1'b0;
            m_sat_q    <= 1'b0;
        end else begin
            data_s0_q  <= data_s0_d;
            vld_q      <= vld_d;
            acc_q      <= acc_d;
            last_q     <= last_d;
            tree_q     <= tree_d;
            acc_reg_q  <= acc_reg_d;
            sat_flag_q <= sat_flag_d;
            m_valid_q  <= m_valid_d;
            m_count_q  <= m_count_d;
            m_frame_q  <= m_frame_d;
            m_sat_q    <= m_sat_d;
        end
    end
endmodule

// File: tb/tb_popcount_pipe_acc.sv
// Bench for popcount_pipe_acc: directed and random traffic on a 64/16 core,
// a 64/8 core for saturation, and narrow widths swept with random traffic.
module tb_popcount_pipe_acc;
    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic rst_x = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    popcount_pipe_acc_if #(.DIN_WIDTH(64), .ACC_WIDTH(16)) pif ();
    popcount_pipe_acc #(.DIN_WIDTH(64), .ACC_WIDTH(16)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (pif)
    );

    popcount_pipe_acc_if #(.DIN_WIDTH(64), .ACC_WIDTH(8)) sif ();
    popcount_pipe_acc #(.DIN_WIDTH(64), .ACC_WIDTH(8)) u_sat (
        .clk (clk),
        .rst (rst_x),
        .bus (sif)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ones(input int n);
        logic [63:0] one = 64'd1;
        if (n >= 64) return '1;
        return (one << n) - one;
    endfunction

    // ---------------- reference model for the 64/16 core ----------------
    // Expected results packed as count | frame<<16 | sat<<17.
    int          expq[$];
    int          tq[$];
    int          macc = 0;
    bit          msat = 1'b0;
    int          cyc = 0;
    bit          lat_on = 1'b1;
    bit          rnd_ready = 1'b0;
    bit          fired;
    bit          dv_valid = 1'b0;
    bit          dv_xor = 1'b0;
    bit          dv_acc = 1'b0;
    bit          dv_last = 1'b0;
    bit          dv_ready = 1'b1;
    logic [63:0] dv_data = '0;
    logic [63:0] dv_ref = '0;

    task automatic model_push(input logic [63:0] d, input logic [63:0] r,
                              input bit x, input bit a, input bit l);
        int c;
        int tot;
        c = $countones(x ? (d ^ r) : d);
        if (!a) begin
            expq.push_back(c);
            tq.push_back(cyc);
        end else begin
            tot = macc + c;
            if (tot > 65535) begin
                tot  = 65535;
                msat = 1'b1;
            end
            if (l) begin
                expq.push_back(tot | (1 << 16) | (int'(msat) << 17));
                tq.push_back(cyc);
                macc = 0;
                msat = 1'b0;
            end else begin
                macc = tot;
            end
        end
    endtask

    task automatic tick();
        int e;
        @(negedge clk);
        pif.s_valid = dv_valid;
        pif.s_data  = dv_data;
        pif.s_ref   = dv_ref;
        pif.s_xor   = dv_xor;
        pif.s_acc   = dv_acc;
        pif.s_last  = dv_last;
        pif.m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : dv_ready;
        #1;
        cyc++;
        check_val("s_ready_adv", 64'(pif.s_ready), 64'(!pif.m_valid || pif.m_ready));
        if (pif.m_valid) begin
            if (expq.size() == 0) begin
                check_val("spurious_out", 64'(pif.m_valid), 64'(0));
            end else begin
                e = expq[0];
                check_val("m_count", 64'(pif.m_count), 64'(e & 32'hFFFF));
                check_val("m_frame", 64'(pif.m_frame), 64'((e >> 16) & 1));
                check_val("m_sat", 64'(pif.m_sat), 64'((e >> 17) & 1));
                if (pif.m_ready) begin
                    if (lat_on) check_val("latency", 64'(cyc - tq[0]), 64'(7));
                    void'(expq.pop_front());
                    void'(tq.pop_front());
                end
            end
        end
        fired = pif.s_valid && pif.s_ready;
        if (fired) model_push(pif.s_data, pif.s_ref, pif.s_xor, pif.s_acc, pif.s_last);
    endtask

    task automatic send(input logic [63:0] d, input logic [63:0] r,
                        input bit x, input bit a, input bit l);
        int n;
        dv_data  = d;
        dv_ref   = r;
        dv_xor   = x;
        dv_acc   = a;
        dv_last  = l;
        dv_valid = 1'b1;
        n = 0;
        fired = 1'b0;
        while (!fired && n < 100) begin
            tick();
            n++;
        end
        if (!fired) check_val("send_timeout", 64'(0), 64'(1));
        dv_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || pif.m_valid) && n < 300) begin
            tick();
            n++;
        end
        check_val("drain_left", 64'(expq.size()), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b1;
        dv_valid    = 1'b0;
        pif.s_valid = 1'b0;
        pif.m_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_val("rst_m_valid", 64'(pif.m_valid), 64'(0));
        check_val("rst_m_count", 64'(pif.m_count), 64'(0));
        check_val("rst_s_ready", 64'(pif.s_ready), 64'(1));
        expq.delete();
        tq.delete();
        macc = 0;
        msat = 1'b0;
    endtask

    // ---------------- saturation core (ACC_WIDTH = 8) ----------------
    bit sat_done = 1'b0;

    initial begin : sat_seq
        int n;
        sif.s_valid = 1'b0;
        sif.s_data  = '0;
        sif.s_ref   = '0;
        sif.s_xor   = 1'b0;
        sif.s_acc   = 1'b0;
        sif.s_last  = 1'b0;
        sif.m_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_x = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            sif.s_valid = 1'b1;
            sif.s_data  = '1;
            sif.s_acc   = 1'b1;
            sif.s_last  = (i == 4);
        end
        @(negedge clk);
        sif.s_valid = 1'b0;
        #1;
        n = 0;
        while (!sif.m_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("sat_valid", 64'(sif.m_valid), 64'(1));
        check_val("sat_count", 64'(sif.m_count), 64'(255));
        check_val("sat_flag", 64'(sif.m_sat), 64'(1));
        check_val("sat_frame", 64'(sif.m_frame), 64'(1));
        @(negedge clk);
        sif.s_valid = 1'b1;
        sif.s_data  = 64'h7;
        sif.s_acc   = 1'b1;
        sif.s_last  = 1'b1;
        @(negedge clk);
        sif.s_valid = 1'b0;
        #1;
        n = 0;
        while (!sif.m_valid && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        check_val("sat2_valid", 64'(sif.m_valid), 64'(1));
        check_val("sat2_count", 64'(sif.m_count), 64'(3));
        check_val("sat2_flag", 64'(sif.m_sat), 64'(0));
        check_val("sat2_frame", 64'(sif.m_frame), 64'(1));
        sat_done = 1'b1;
    end

    // ---------------- narrow-width sweep ----------------
    for (genvar g = 0; g < 4; g++) begin : g_sw
        localparam int W = (g == 0) ? 1 : (g == 1) ? 6 : (g == 2) ? 7 : 13;
        bit done = 1'b0;

        popcount_pipe_acc_if #(.DIN_WIDTH(W), .ACC_WIDTH(16)) wif ();
        popcount_pipe_acc #(.DIN_WIDTH(W), .ACC_WIDTH(16)) u_sw (
            .clk (clk),
            .rst (rst_x),
            .bus (wif)
        );

        initial begin : sw_seq
            int exq[$];
            int facc;
            int c;
            logic [17:0] got;
            facc        = 0;
            wif.s_valid = 1'b0;
            wif.s_data  = '0;
            wif.s_ref   = '0;
            wif.s_xor   = 1'b0;
            wif.s_acc   = 1'b0;
            wif.s_last  = 1'b0;
            wif.m_ready = 1'b0;
            wait (rst_x == 1'b0);
            for (int i = 0; i < 200; i++) begin
                @(negedge clk);
                wif.s_valid = (i < 160) && ($urandom_range(0, 3) != 0);
                wif.s_data  = W'($urandom);
                wif.s_ref   = W'($urandom);
                wif.s_xor   = 1'($urandom_range(0, 1));
                wif.s_acc   = 1'($urandom_range(0, 1));
                wif.s_last  = 1'($urandom_range(0, 1));
                wif.m_ready = (i >= 160) || ($urandom_range(0, 2) != 0);
                #1;
                if (wif.m_valid) begin
                    if (exq.size() == 0) begin
                        check_val($sformatf("sw%0d_spurious", W), 64'(wif.m_valid), 64'(0));
                    end else begin
                        got = {wif.m_sat, wif.m_frame, wif.m_count};
                        check_val($sformatf("sw%0d_out", W), 64'(got), 64'(exq[0]));
                        if (wif.m_ready) void'(exq.pop_front());
                    end
                end
                if (wif.s_valid && wif.s_ready) begin
                    c = $countones(wif.s_xor ? (wif.s_data ^ wif.s_ref) : wif.s_data);
                    if (!wif.s_acc) begin
                        exq.push_back(c);
                    end else if (wif.s_last) begin
                        exq.push_back((facc + c) | (1 << 16));
                        facc = 0;
                    end else begin
                        facc = facc + c;
                    end
                end
            end
            check_val($sformatf("sw%0d_drained", W), 64'(exq.size()), 64'(0));
            done = 1'b1;
        end
    end

    // ---------------- main sequence on the 64/16 core ----------------
    initial begin : main_seq
        int n;
        pif.s_valid = 1'b0;
        pif.s_data  = '0;
        pif.s_ref   = '0;
        pif.s_xor   = 1'b0;
        pif.s_acc   = 1'b0;
        pif.s_last  = 1'b0;
        pif.m_ready = 1'b1;
        do_reset();

        // single beats, including latency
        send('1, '0, 1'b0, 1'b0, 1'b0);
        drain();
        send('0, '0, 1'b0, 1'b0, 1'b0);
        send(64'h8000_0000_0000_0001, '0, 1'b0, 1'b0, 1'b0);
        drain();

        // Hamming distance mode
        send(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b1, 1'b0, 1'b0);
        send(64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 1'b1, 1'b0, 1'b0);
        send(64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 1'b0, 1'b0, 1'b0);
        drain();

        // frame of 10+20+30+5, then the same with a count-7 beat interleaved
        send(ones(10), '0, 1'b0, 1'b1, 1'b0);
        send(ones(20), '0, 1'b0, 1'b1, 1'b0);
        send(ones(30), '0, 1'b0, 1'b1, 1'b0);
        send(ones(5),  '0, 1'b0, 1'b1, 1'b1);
        drain();
        send(ones(10), '0, 1'b0, 1'b1, 1'b0);
        send(ones(20), '0, 1'b0, 1'b1, 1'b0);
        send(ones(7),  '0, 1'b0, 1'b0, 1'b1);
        send(ones(30), '0, 1'b0, 1'b1, 1'b0);
        send(ones(5),  '0, 1'b0, 1'b1, 1'b1);
        drain();

        // one-beat frame
        send(ones(12), '0, 1'b0, 1'b1, 1'b1);
        drain();

        // random back-to-back beats under random backpressure
        lat_on    = 1'b0;
        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            send({$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 (i == 19) ? 1'b1 : 1'($urandom_range(0, 1)));
        end
        drain();
        rnd_ready = 1'b0;
        lat_on    = 1'b1;

        // reset with a partial frame and three beats in flight
        send(ones(10), '0, 1'b0, 1'b1, 1'b0);
        send(ones(20), '0, 1'b0, 1'b1, 1'b0);
        send(ones(3),  '0, 1'b0, 1'b0, 1'b0);
        send(ones(4),  '0, 1'b0, 1'b0, 1'b0);
        send(ones(5),  '0, 1'b0, 1'b0, 1'b0);
        do_reset();
        repeat (12) tick();
        send(ones(9), '0, 1'b0, 1'b1, 1'b1);
        drain();

        n = 0;
        while (!(sat_done && g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done)
               && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check_val("workers_done",
                  64'(sat_done && g_sw[0].done && g_sw[1].done && g_sw[2].done && g_sw[3].done),
                  64'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
